// File: rtl/exp_accel_queued.sv
// exp_accel_queued: fixed-point e^x series engine.
// Computes sum_{k=0..TERMS-1} x^k/k! with x = {ui,vi} (FRAC_W fraction bits).
// Has a 1-deep operand queue (wrStart/ready) and a held result port (wrReq/wrAck).
// Terms are formed iteratively: term *= x, then term *= floor(2^FRAC_W/k).
// Iteration stops early once a term truncates to zero.
// Both the term and the accumulator saturate to all-ones and set ovf.
module exp_accel_queued #(
    parameter int INT_W  = 2,
    parameter int FRAC_W = 5,
    parameter int OUT_W  = 21,
    parameter int TERMS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrStart,
    output logic                ready,
    input  logic [INT_W-1:0]    ui,
    input  logic [FRAC_W-1:0]   vi,
    output logic                wrReq,
    input  logic                wrAck,
    output logic [OUT_W-1:0]    wrData,
    output logic                ovf,
    output logic                done
);

    localparam int XW = INT_W + FRAC_W;
    localparam int PW = OUT_W + XW;
    localparam int KW = $clog2(TERMS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MULX  = 3'd2;
    localparam logic [2:0] S_MULR  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [OUT_W-1:0] ONE = OUT_W'(2 ** FRAC_W);

    logic [2:0]       state_q,  state_d;
    logic [XW-1:0]    x_q,      x_d;
    logic [XW-1:0]    p_q,      p_d;
    logic             p_valid_q, p_valid_d;
    logic [OUT_W-1:0] term_q,   term_d;
    logic [OUT_W-1:0] acc_q,    acc_d;
    logic [KW-1:0]    k_q,      k_d;
    logic             ovf_r_q,  ovf_r_d;
    logic [OUT_W-1:0] wrdata_q, wrdata_d;
    logic             ovf_o_q,  ovf_o_d;
    logic             done_q,   done_d;

    logic [FRAC_W:0]  recip_tbl [TERMS];
    logic [PW-1:0]    prod_x;
    logic [PW-1:0]    px;
    logic [PW-1:0]    prod_r;
    logic [OUT_W-1:0] term_r;
    logic [OUT_W:0]   acc_sum;
    logic             accept;

    // Constant reciprocal table R[k] = floor(2^FRAC_W / k); entry 0 is never used
    for (genvar gi = 0; gi < TERMS; gi++) begin : g_recip
        assign recip_tbl[gi] = (FRAC_W + 1)'((2 ** FRAC_W) / ((gi == 0) ? 1 : gi));
    end

    assign ready  = !p_valid_q;
    assign wrReq  = (state_q == S_WRITE);
    assign wrData = wrdata_q;
    assign ovf    = ovf_o_q;
    assign done   = done_q;

    // Shared datapath: x-multiply, reciprocal-multiply and accumulate
    always_comb begin
        prod_x  = PW'(term_q) * PW'(x_q);
        px      = prod_x >> FRAC_W;
        prod_r  = PW'(term_q) * PW'(recip_tbl[k_q]);
        term_r  = OUT_W'(prod_r >> FRAC_W);
        acc_sum = {1'b0, acc_q} + (OUT_W + 1)'(term_r);
    end

    // Next-state logic for the FSM, operand queue and result registers
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        p_d       = p_q;
        p_valid_d = p_valid_q;
        term_d    = term_q;
        acc_d     = acc_q;
        k_d       = k_q;
        ovf_r_d   = ovf_r_q;
        wrdata_d  = wrdata_q;
        ovf_o_d   = ovf_o_q;
        done_d    = 1'b0;

        accept = wrStart && !p_valid_q;

        // Any accept while not idle lands in the pending slot
        if (accept && (state_q != S_IDLE)) begin
            p_d       = {ui, vi};
            p_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // A pending operand can be left over when it arrived in the
                // same cycle as the final ack; drain it before new accepts.
                if (p_valid_q) begin
                    x_d       = p_q;
                    p_valid_d = 1'b0;
                    state_d   = S_LOAD;
                end else if (accept) begin
                    x_d     = {ui, vi};
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = ONE;
                term_d  = ONE;
                k_d     = KW'(1);
                ovf_r_d = 1'b0;
                state_d = S_MULX;
            end
            S_MULX: begin
                if (|px[PW-1:OUT_W]) begin
                    term_d  = '1;
                    ovf_r_d = 1'b1;
                end else begin
                    term_d = px[OUT_W-1:0];
                end
                state_d = S_MULR;
            end
            S_MULR: begin
                term_d = term_r;
                if (acc_sum[OUT_W]) begin
                    acc_d   = '1;
                    ovf_r_d = 1'b1;
                end else begin
                    acc_d = acc_sum[OUT_W-1:0];
                end
                if ((term_r == '0) || (k_q == KW'(TERMS - 1))) begin
                    wrdata_d = acc_d;
                    ovf_o_d  = ovf_r_d;
                    state_d  = S_WRITE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_MULX;
                end
            end
            S_WRITE: begin
                if (wrAck) begin
                    done_d = 1'b1;
                    if (p_valid_q) begin
                        x_d       = p_q;
                        p_valid_d = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            term_q    <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            ovf_r_q   <= 1'b0;
            wrdata_q  <= '0;
            ovf_o_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
            term_q    <= term_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            ovf_r_q   <= ovf_r_d;
            wrdata_q  <= wrdata_d;
            ovf_o_q   <= ovf_o_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_exp_accel_queued.sv
// tb_exp_accel_queued: directed and randomized checks of exp_accel_queued
// against a behavioural series model.
module tb_exp_accel_queued;

    localparam int INT_W  = 2;
    localparam int FRAC_W = 5;
    localparam int OUT_W  = 21;
    localparam int TERMS  = 8;
    localparam int S_OUT_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wrStart = 1'b0;
    logic               ready;
    logic [INT_W-1:0]   ui = '0;
    logic [FRAC_W-1:0]  vi = '0;
    logic               wrReq;
    logic               wrAck = 1'b0;
    logic [OUT_W-1:0]   wrData;
    logic               ovf;
    logic               done;

    logic               s_wrStart = 1'b0;
    logic               s_ready;
    logic [INT_W-1:0]   s_ui = '0;
    logic [FRAC_W-1:0]  s_vi = '0;
    logic               s_wrReq;
    logic               s_wrAck = 1'b0;
    logic [S_OUT_W-1:0] s_wrData;
    logic               s_ovf;
    logic               s_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exp_accel_queued #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .TERMS(TERMS)) u_dut (
        .clk(clk), .rst(rst), .wrStart(wrStart), .ready(ready), .ui(ui), .vi(vi),
        .wrReq(wrReq), .wrAck(wrAck), .wrData(wrData), .ovf(ovf), .done(done)
    );

    exp_accel_queued #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_W(S_OUT_W), .TERMS(TERMS)) u_sat (
        .clk(clk), .rst(rst), .wrStart(s_wrStart), .ready(s_ready), .ui(s_ui), .vi(s_vi),
        .wrReq(s_wrReq), .wrAck(s_wrAck), .wrData(s_wrData), .ovf(s_ovf), .done(s_done)
    );

    // Series model: truncating fixed point, saturation to 2^outw-1, early stop on zero term
    function automatic longint unsigned model_exp(input int x, input int outw, output bit ov);
        longint unsigned one  = 64'd1 << FRAC_W;
        longint unsigned maxv = (64'd1 << outw) - 1;
        longint unsigned acc  = one;
        longint unsigned term = one;
        longint unsigned p;
        ov = 1'b0;
        for (int k = 1; k < TERMS; k++) begin
            p = (term * longint'(x)) >> FRAC_W;
            if (p > maxv) begin
                term = maxv;
                ov = 1'b1;
            end else begin
                term = p;
            end
            term = (term * (one / longint'(k))) >> FRAC_W;
            acc = acc + term;
            if (acc > maxv) begin
                acc = maxv;
                ov = 1'b1;
            end
            if (term == 0) break;
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b1 || wrReq !== 1'b0 || wrData !== '0 || ovf !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b wrReq=%b wrData=%0d ovf=%b done=%b, want 1 0 0 0 0",
                     ready, wrReq, wrData, ovf, done);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_x_zero();
        int cyc;
        wrAck = 1'b1;
        ui = 2'd0; vi = 5'd0; wrStart = 1'b1;
        tick();
        wrStart = 1'b0;
        cyc = 0;
        while (!wrReq && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL x0_latency: got %0d cycles, want 3", cyc);
        end
        checks++;
        if (wrData !== OUT_W'(32) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL x0_result: wrData=%0d ovf=%b, want 32 0", wrData, ovf);
        end
        tick();
        checks++;
        if (done !== 1'b1 || wrReq !== 1'b0) begin
            errors++;
            $display("FAIL x0_done: done=%b wrReq=%b, want 1 0", done, wrReq);
        end
        wrAck = 1'b0;
        tick();
    endtask

    task automatic test_x_one();
        int cyc;
        wrAck = 1'b1;
        ui = 2'd1; vi = 5'd0; wrStart = 1'b1;
        tick();
        wrStart = 1'b0;
        cyc = 0;
        while (!wrReq && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL x1_latency: got %0d cycles, want 11", cyc);
        end
        checks++;
        if (wrData !== OUT_W'(86) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL x1_result: wrData=%0d ovf=%b, want 86 0", wrData, ovf);
        end
        tick();
        wrAck = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        bit seen;
        wrAck = 1'b0;
        ui = 2'd1; vi = 5'd0; wrStart = 1'b1;
        tick();
        ui = 2'd2; vi = 5'd3;
        tick();
        wrStart = 1'b0;
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_queue_full: ready=%b, want 0", ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || wrReq !== 1'b0 || wrData !== '0 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b wrReq=%b wrData=%0d done=%b ovf=%b, want 1 0 0 0 0",
                     ready, wrReq, wrData, done, ovf);
        end
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wrReq) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: wrReq seen=%b, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int results;
        bit held_ok;
        wrAck = 1'b0;
        ui = 2'd1; vi = 5'd0; wrStart = 1'b1;
        tick();
        ui = 2'd0; vi = 5'd0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_slot: ready=%b, want 1", ready);
        end
        tick();
        ui = 2'd3; vi = 5'd0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_queue_full: ready=%b, want 0", ready);
        end
        repeat (3) tick();
        wrStart = 1'b0;
        cyc = 0;
        while (!wrReq && cyc < 100) begin tick(); cyc++; end
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wrReq !== 1'b1 || wrData !== OUT_W'(86)) held_ok = 1'b0;
            tick();
        end
        checks++;
        if (held_ok !== 1'b1 || wrData !== OUT_W'(86)) begin
            errors++;
            $display("FAIL b2b_hold: wrReq=%b wrData=%0d, want 1 86 held", wrReq, wrData);
        end
        results = 1;
        wrAck = 1'b1;
        tick();
        wrAck = 1'b0;
        checks++;
        if (done !== 1'b1 || wrReq !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b wrReq=%b, want 1 0", done, wrReq);
        end
        tick();
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_slot_free: ready=%b done=%b, want 1 0", ready, done);
        end
        cyc = 0;
        while (!wrReq && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (wrReq !== 1'b1 || wrData !== OUT_W'(32) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: wrReq=%b wrData=%0d ovf=%b, want 1 32 0", wrReq, wrData, ovf);
        end
        wrAck = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (wrReq) results++;
            tick();
        end
        wrAck = 1'b0;
        results++;
        checks++;
        if (results !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, want 2", results);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        s_wrAck = 1'b0;
        s_ui = 2'd3; s_vi = 5'd31; s_wrStart = 1'b1;
        tick();
        s_wrStart = 1'b0;
        cyc = 0;
        while (!s_wrReq && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (s_wrReq !== 1'b1 || s_wrData !== 8'd255 || s_ovf !== 1'b1) begin
            errors++;
            $display("FAIL saturation: wrReq=%b wrData=%0d ovf=%b, want 1 255 1", s_wrReq, s_wrData, s_ovf);
        end
        s_wrAck = 1'b1;
        tick();
        s_wrAck = 1'b0;
    endtask

    task automatic test_random();
        longint unsigned q_data[$];
        bit q_ovf[$];
        longint unsigned ed;
        bit eo;
        int accepted = 0;
        int drained;
        bit bad_order = 1'b0;
        bit extra = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            wrStart = ($urandom_range(0, 2) != 0);
            ui = INT_W'($urandom);
            vi = FRAC_W'($urandom);
            wrAck = ($urandom_range(0, 3) != 0);
            if (wrStart && ready) begin
                q_data.push_back(model_exp(int'({ui, vi}), OUT_W, eo));
                q_ovf.push_back(eo);
                accepted++;
            end
            if (wrReq && wrAck) begin
                if (q_data.size() == 0) begin
                    extra = 1'b1;
                end else begin
                    ed = q_data.pop_front();
                    eo = q_ovf.pop_front();
                    checks++;
                    if (64'(wrData) !== ed || ovf !== eo) begin
                        errors++;
                        bad_order = 1'b1;
                        $display("FAIL random_result: wrData=%0d ovf=%b, want %0d %b", wrData, ovf, ed, eo);
                    end
                end
            end
            tick();
        end
        wrStart = 1'b0;
        wrAck = 1'b1;
        drained = 0;
        while (drained < 300) begin
            if (wrReq) begin
                if (q_data.size() == 0) begin
                    extra = 1'b1;
                end else begin
                    ed = q_data.pop_front();
                    eo = q_ovf.pop_front();
                    checks++;
                    if (64'(wrData) !== ed || ovf !== eo) begin
                        errors++;
                        $display("FAIL random_drain: wrData=%0d ovf=%b, want %0d %b", wrData, ovf, ed, eo);
                    end
                end
            end
            tick();
            drained++;
        end
        wrAck = 1'b0;
        checks++;
        if (q_data.size() != 0 || extra !== 1'b0) begin
            errors++;
            $display("FAIL random_count: %0d results missing, extra=%b, want 0 0", q_data.size(), extra);
        end
        checks++;
        if (accepted < 20) begin
            errors++;
            $display("FAIL random_accepts: got %0d accepted, want at least 20", accepted);
        end
        if (bad_order) $display("random stream saw out-of-order or wrong values");
    endtask

    initial begin
        test_reset();
        test_x_zero();
        test_x_one();
        test_reset_midrun();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
